mlp_sequencer: RTL and testbench
================================

Name: mlp_sequencer

Overview:
- Sequences the two-layer MLP datapath (MAC accumulator, weight ROM, input/hidden activation buffers) for one forward pass.
- Started by MLP_go from the forward-pass FSM; returns a one-cycle MLP_done pulse.
- Issues buffer and ROM read addresses, aligns accumulate enables to memory read latency, and issues per-neuron clear and writeback strobes.
- Pure controller: all arithmetic lives in the datapath.

Parameters:
N_IN, 64, input-layer fan-in (averaged pixels)
N_HID, 16, hidden neurons
N_OUT, 10, output neurons (digits)
RD_LAT, 2, cycles from address issue to data at MAC input (>=1)
AW, 11, width of w_addr; must hold N_IN*N_HID+N_HID*N_OUT-1

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
MLP_go  in  1  level start request from forward-pass FSM
MLP_done  out  1  one-cycle pulse: pass complete
busy  out  1  high in any state except IDLE
layer_sel  out  1  0 = hidden layer (read input buffer, ReLU on writeback); 1 = output layer (read hidden buffer, no activation)
in_addr  out  clog2(max(N_IN,N_HID))  activation buffer read address
w_addr  out  AW  weight ROM read address
acc_clr  out  1  clear accumulator
acc_en  out  1  accumulate product present at MAC input this cycle
wr_en  out  1  write accumulator (+bias, +activation per layer_sel) to destination
wr_addr  out  clog2(max(N_HID,N_OUT))  destination neuron index within layer
b_addr  out  clog2(N_HID+N_OUT)  bias ROM address: global neuron index, valid with wr_en

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, all counters 0, RD_LAT shift register cleared, armed=1.
  - All outputs 0.
  - Reset mid-pass aborts immediately; no MLP_done is issued.
- States: IDLE, CLR, ISSUE, DRAIN, WB, DONE.
- IDLE:
  - If MLP_go=1 and armed=1 -> CLR; layer=0, neuron=0, w_addr=0.
  - armed clears on DONE and sets when MLP_go is sampled 0 in IDLE, so a held MLP_go never starts a second pass.
- CLR (1 cycle):
  - acc_clr=1; input index i=0 -> ISSUE.
- ISSUE (fan-in cycles: N_IN for layer 0, N_HID for layer 1):
  - Each cycle drives in_addr=i and the current w_addr, then i++ and w_addr++.
  - After the last index -> DRAIN.
  - w_addr runs continuously across neurons and layers: layer 0 uses 0..N_IN*N_HID-1, layer 1 continues from N_IN*N_HID.
- acc_en: the ISSUE-valid flag delayed by exactly RD_LAT cycles (shift register). Exactly fan-in acc_en pulses per neuron.
- DRAIN (RD_LAT cycles):
  - No issue; waits until the last acc_en has been asserted -> WB.
- WB (1 cycle):
  - wr_en=1, wr_addr=neuron, b_addr=neuron+(layer ? N_HID : 0).
  - If neuron is not the last in its layer: neuron++ -> CLR.
  - Else if layer=0: layer=1, neuron=0 -> CLR.
  - Else -> DONE.
- DONE (1 cycle):
  - MLP_done=1 -> IDLE.
- layer_sel equals the layer register and is stable across CLR..WB of each neuron.
- Cycles per neuron = 1 + fan-in + RD_LAT + 1.
- Total pass length = N_HID*(N_IN+RD_LAT+2) + N_OUT*(N_HID+RD_LAT+2) + 1 cycles, counted from the first CLR cycle through DONE inclusive.
- Default latency: 16*68 + 10*20 + 1 = 1289 cycles.
- MLP_go dropping mid-pass is ignored; the pass runs to completion.
- acc_clr, acc_en and wr_en are never high in the same cycle.
- in_addr and w_addr hold their last value outside ISSUE; they are don't-care to the datapath.

Test Plan:
- Reset behaviour: hold reset=0 with MLP_go=1 -> all outputs 0 and state IDLE. Release reset -> CLR on the next edge, acc_clr=1.
- Small-config full pass (N_IN=4, N_HID=3, N_OUT=2, RD_LAT=1):
  - MLP_go=1 -> MLP_done high exactly 34 cycles after the first CLR cycle (cycle 33, zero-based).
  - 18 acc_en pulses total.
  - wr_en at cycles 6,13,20 (layer_sel=0, wr_addr 0,1,2) and 26,32 (layer_sel=1, wr_addr 0,1); b_addr sequence 0..4.
  - w_addr sequence 0..17, monotonic.
- Latency alignment with RD_LAT=3, N_IN=4: each acc_en is exactly 3 cycles after its ISSUE cycle; 4 acc_en per hidden neuron; wr_en is 1 cycle after the last acc_en.
- Held start: keep MLP_go=1 for 100 cycles after MLP_done -> no second CLR. Drop MLP_go for 1 cycle, then raise it -> new pass starts and w_addr restarts at 0.
- Abort: pull reset=0 at the 2nd neuron's ISSUE in layer 0 -> outputs 0 asynchronously and no MLP_done. Release reset and pulse MLP_go -> full-length pass with correct counts.
- Default parameters: one pass -> MLP_done at cycle 1288; 1184 acc_en (1024+160); 26 wr_en; final w_addr issued = 1183.

Source files
------------

// File: rtl/mlp_sequencer.sv
// Control sequencer for a two-layer MLP forward pass: walks neurons and fan-in,
// issues buffer/ROM addresses and aligns MAC clear/accumulate/writeback strobes.
module mlp_sequencer #(
    parameter int unsigned N_IN   = 64,
    parameter int unsigned N_HID  = 16,
    parameter int unsigned N_OUT  = 10,
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned AW     = 11,
    localparam int unsigned IAW   = $clog2((N_IN > N_HID) ? N_IN : N_HID),
    localparam int unsigned OW    = $clog2((N_HID > N_OUT) ? N_HID : N_OUT),
    localparam int unsigned BW    = $clog2(N_HID + N_OUT)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           MLP_go,
    output logic           MLP_done,
    output logic           busy,
    output logic           layer_sel,
    output logic [IAW-1:0] in_addr,
    output logic [AW-1:0]  w_addr,
    output logic           acc_clr,
    output logic           acc_en,
    output logic           wr_en,
    output logic [OW-1:0]  wr_addr,
    output logic [BW-1:0]  b_addr
);

    localparam int unsigned CW = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_ISSUE,
        S_DRAIN,
        S_WB,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            layer_q, layer_d;
    logic [OW-1:0]   neuron_q, neuron_d;
    logic [IAW-1:0]  idx_q, idx_d;
    logic [AW-1:0]   wcnt_q, wcnt_d;
    logic [CW-1:0]   drain_q, drain_d;
    logic            armed_q, armed_d;
    logic [RD_LAT:0] iss_sr_q;

    logic [IAW-1:0]  fan_last;
    logic [OW-1:0]   neuron_last;
    logic [BW-1:0]   b_addr_d;

    // Layer-dependent loop bounds
    always_comb begin
        fan_last    = layer_q ? IAW'(N_HID - 1) : IAW'(N_IN - 1);
        neuron_last = layer_q ? OW'(N_OUT - 1)  : OW'(N_HID - 1);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            layer_q  <= 1'b0;
            neuron_q <= '0;
            idx_q    <= '0;
            wcnt_q   <= '0;
            drain_q  <= '0;
            armed_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            layer_q  <= layer_d;
            neuron_q <= neuron_d;
            idx_q    <= idx_d;
            wcnt_q   <= wcnt_d;
            drain_q  <= drain_d;
            armed_q  <= armed_d;
        end
    end

    // Next-state and counter updates
    always_comb begin
        state_d  = state_q;
        layer_d  = layer_q;
        neuron_d = neuron_q;
        idx_d    = idx_q;
        wcnt_d   = wcnt_q;
        drain_d  = drain_q;
        armed_d  = armed_q;

        case (state_q)
            S_IDLE: begin
                if (!MLP_go) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d  = S_CLR;
                    layer_d  = 1'b0;
                    neuron_d = '0;
                    wcnt_d   = '0;
                end
            end
            S_CLR: begin
                idx_d   = '0;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                // Weight address runs on across neurons and layers
                wcnt_d = wcnt_q + AW'(1);
                if (idx_q == fan_last) begin
                    drain_d = '0;
                    state_d = S_DRAIN;
                end else begin
                    idx_d = idx_q + IAW'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == CW'(RD_LAT - 1)) begin
                    state_d = S_WB;
                end else begin
                    drain_d = drain_q + CW'(1);
                end
            end
            S_WB: begin
                if (neuron_q != neuron_last) begin
                    neuron_d = neuron_q + OW'(1);
                    state_d  = S_CLR;
                end else if (!layer_q) begin
                    layer_d  = 1'b1;
                    neuron_d = '0;
                    state_d  = S_CLR;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Held MLP_go must be seen low before another pass may start
                armed_d = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        b_addr_d = '0;
        if (state_d == S_WB) begin
            b_addr_d = BW'(neuron_d) + (layer_d ? BW'(N_HID) : BW'(0));
        end
    end

    // Outputs registered from next-state so they line up with the state they describe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            MLP_done  <= 1'b0;
            busy      <= 1'b0;
            layer_sel <= 1'b0;
            in_addr   <= '0;
            w_addr    <= '0;
            acc_clr   <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            b_addr    <= '0;
            iss_sr_q  <= '0;
        end else begin
            MLP_done  <= (state_d == S_DONE);
            busy      <= (state_d != S_IDLE);
            layer_sel <= layer_d;
            acc_clr   <= (state_d == S_CLR);
            wr_en     <= (state_d == S_WB);
            wr_addr   <= (state_d == S_WB) ? neuron_d : '0;
            b_addr    <= b_addr_d;
            if (state_d == S_ISSUE) begin
                in_addr <= idx_d;
                w_addr  <= wcnt_d;
            end
            iss_sr_q <= {iss_sr_q[RD_LAT-1:0], (state_d == S_ISSUE)};
        end
    end

    // Bit 0 marks an issue this cycle; bit RD_LAT marks its data reaching the MAC
    assign acc_en = iss_sr_q[RD_LAT];

endmodule

// File: tb/tb_mlp_sequencer.sv
// Bench for mlp_sequencer: three parameterisations checked cycle by cycle against
// an event schedule derived from the neuron/fan-in walk of a forward pass.
module tb_mlp_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;
    logic go_a, go_b, go_c;

    logic       done_a, busy_a, lay_a, clr_a, en_a, wr_a;
    logic [1:0] in_a;
    logic [4:0] w_a;
    logic [1:0] wra_a;
    logic [2:0] ba_a;

    logic       done_b, busy_b, lay_b, clr_b, en_b, wr_b;
    logic [1:0] in_b;
    logic [4:0] w_b;
    logic [1:0] wra_b;
    logic [2:0] ba_b;

    logic        done_c, busy_c, lay_c, clr_c, en_c, wr_c;
    logic [5:0]  in_c;
    logic [10:0] w_c;
    logic [3:0]  wra_c;
    logic [4:0]  ba_c;

    mlp_sequencer #(.N_IN(4), .N_HID(3), .N_OUT(2), .RD_LAT(1), .AW(5)) u_a (
        .clk(clk), .reset(rst_a), .MLP_go(go_a), .MLP_done(done_a), .busy(busy_a),
        .layer_sel(lay_a), .in_addr(in_a), .w_addr(w_a), .acc_clr(clr_a),
        .acc_en(en_a), .wr_en(wr_a), .wr_addr(wra_a), .b_addr(ba_a));

    mlp_sequencer #(.N_IN(4), .N_HID(3), .N_OUT(2), .RD_LAT(3), .AW(5)) u_b (
        .clk(clk), .reset(rst_b), .MLP_go(go_b), .MLP_done(done_b), .busy(busy_b),
        .layer_sel(lay_b), .in_addr(in_b), .w_addr(w_b), .acc_clr(clr_b),
        .acc_en(en_b), .wr_en(wr_b), .wr_addr(wra_b), .b_addr(ba_b));

    mlp_sequencer u_c (
        .clk(clk), .reset(rst_c), .MLP_go(go_c), .MLP_done(done_c), .busy(busy_c),
        .layer_sel(lay_c), .in_addr(in_c), .w_addr(w_c), .acc_clr(clr_c),
        .acc_en(en_c), .wr_en(wr_c), .wr_addr(wra_c), .b_addr(ba_c));

    // Observation mux onto common 32-bit views
    logic [1:0]  sel;
    logic        o_busy, o_clr, o_en, o_wr, o_done, o_lay, o_any;
    logic [31:0] o_in, o_w, o_wra, o_ba;

    always_comb begin
        o_busy = busy_a; o_clr = clr_a; o_en = en_a; o_wr = wr_a; o_done = done_a; o_lay = lay_a;
        o_in = 32'(in_a); o_w = 32'(w_a); o_wra = 32'(wra_a); o_ba = 32'(ba_a);
        case (sel)
            2'd1: begin
                o_busy = busy_b; o_clr = clr_b; o_en = en_b; o_wr = wr_b; o_done = done_b; o_lay = lay_b;
                o_in = 32'(in_b); o_w = 32'(w_b); o_wra = 32'(wra_b); o_ba = 32'(ba_b);
            end
            2'd2: begin
                o_busy = busy_c; o_clr = clr_c; o_en = en_c; o_wr = wr_c; o_done = done_c; o_lay = lay_c;
                o_in = 32'(in_c); o_w = 32'(w_c); o_wra = 32'(wra_c); o_ba = 32'(ba_c);
            end
            default: ;
        endcase
        o_any = o_busy | o_clr | o_en | o_wr | o_done | o_lay |
                (|o_in) | (|o_w) | (|o_wra) | (|o_ba);
    end

    localparam int MAXC = 1400;

    // Expected event schedule, indexed by cycle offset from the first CLR cycle
    bit m_clr [MAXC];
    bit m_iss [MAXC];
    bit m_en  [MAXC];
    bit m_wr  [MAXC];
    bit m_done[MAXC];
    bit m_lay [MAXC];
    int m_in  [MAXC];
    int m_w   [MAXC];
    int m_wra [MAXC];
    int m_ba  [MAXC];
    int m_len, m_weights, m_neurons, m_formula;

    int n_cmp = 0;
    int n_err = 0;
    int cur_cyc;
    int obs_en, obs_wr, obs_done_at;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s sel=%0d cyc=%0d: observed %0h expected %0h", tag, sel, cur_cyc, obs, exp);
        end
    endtask

    task automatic build_model(input int nin, input int nhid, input int nout, input int rdl);
        int t, w, fan, nn;
        for (int k = 0; k < MAXC; k++) begin
            m_clr[k] = 0; m_iss[k] = 0; m_en[k] = 0; m_wr[k] = 0; m_done[k] = 0; m_lay[k] = 0;
            m_in[k] = 0; m_w[k] = 0; m_wra[k] = 0; m_ba[k] = 0;
        end
        t = 0;
        w = 0;
        for (int l = 0; l < 2; l++) begin
            fan = (l == 0) ? nin : nhid;
            nn  = (l == 0) ? nhid : nout;
            for (int n = 0; n < nn; n++) begin
                for (int k = 0; k < fan + rdl + 2; k++) m_lay[t+k] = (l == 1);
                m_clr[t] = 1;
                for (int i = 0; i < fan; i++) begin
                    m_iss[t+1+i]    = 1;
                    m_in[t+1+i]     = i;
                    m_w[t+1+i]      = w;
                    w++;
                    m_en[t+1+i+rdl] = 1;
                end
                m_wr[t+1+fan+rdl]  = 1;
                m_wra[t+1+fan+rdl] = n;
                m_ba[t+1+fan+rdl]  = n + ((l == 1) ? nhid : 0);
                t += fan + rdl + 2;
            end
        end
        m_done[t] = 1;
        m_lay[t]  = 1;
        m_len     = t + 1;
        m_weights = w;
        m_neurons = nhid + nout;
        m_formula = nhid * (nin + rdl + 2) + nout * (nhid + rdl + 2);
    endtask

    // Checks the first ncyc cycles of a pass; go must have been raised just after a negedge
    task automatic check_cycles(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            cur_cyc = c;
            chk("ctrl{busy,clr,en,wr,done}", 32'({o_busy, o_clr, o_en, o_wr, o_done}),
                32'({1'b1, m_clr[c], m_en[c], m_wr[c], m_done[c]}));
            if (c < m_len - 1) chk("layer_sel", 32'(o_lay), 32'(m_lay[c]));
            if (m_iss[c]) begin
                chk("in_addr", o_in, 32'(m_in[c]));
                chk("w_addr", o_w, 32'(m_w[c]));
            end
            if (m_wr[c]) begin
                chk("wr_addr", o_wra, 32'(m_wra[c]));
                chk("b_addr", o_ba, 32'(m_ba[c]));
            end
            if (o_en) obs_en++;
            if (o_wr) obs_wr++;
            if (o_done) obs_done_at = c;
        end
    endtask

    task automatic full_pass();
        obs_en = 0;
        obs_wr = 0;
        obs_done_at = -1;
        check_cycles(m_len);
        chk("acc_en_count", 32'(obs_en), 32'(m_weights));
        chk("wr_en_count", 32'(obs_wr), 32'(m_neurons));
        chk("done_cycle", 32'(obs_done_at), 32'(m_formula));
        chk("last_w_addr", o_w, 32'(m_weights - 1));
        @(negedge clk);
        cur_cyc = m_len;
        chk("idle_after_pass", 32'({o_busy, o_done, o_clr}), 32'(0));
    endtask

    initial begin
        int k;
        sel = 2'd0;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        go_a = 1'b1; go_b = 1'b0; go_c = 1'b0;
        cur_cyc = -1;

        // Reset held with start requested: everything quiet
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #0;
            chk("reset_outputs", 32'(o_any), 32'(0));
        end
        sel = 2'd0;

        // Release with MLP_go high: first CLR on the next edge
        build_model(4, 3, 2, 1);
        rst_b = 1'b1;
        rst_c = 1'b1;
        rst_a = 1'b1;
        full_pass();

        // Held start must not retrigger
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            cur_cyc = c;
            chk("held_go_idle", 32'({o_busy, o_clr}), 32'(0));
        end

        // Drop then re-raise: new pass restarting at w_addr 0
        go_a = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        go_a = 1'b1;
        full_pass();

        // Read latency 3: acc_en alignment
        sel = 2'd1;
        build_model(4, 3, 2, 3);
        repeat ($urandom_range(0, 5)) @(negedge clk);
        go_b = 1'b1;
        full_pass();
        go_b = 1'b0;

        // Abort during the second hidden neuron's issue phase
        sel = 2'd0;
        build_model(4, 3, 2, 1);
        go_a = 1'b0;
        @(negedge clk);
        go_a = 1'b1;
        k = 8 + int'($urandom_range(0, 3));
        obs_en = 0;
        obs_wr = 0;
        obs_done_at = -1;
        check_cycles(k);
        @(posedge clk);
        #2 rst_a = 1'b0;
        #1;
        cur_cyc = k;
        chk("abort_async_zero", 32'(o_any), 32'(0));
        go_a = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            cur_cyc = c;
            if (c == 10) rst_a = 1'b1;
            chk("abort_no_done", 32'({o_busy, o_done}), 32'(0));
        end
        repeat ($urandom_range(0, 4)) @(negedge clk);
        go_a = 1'b1;
        full_pass();
        go_a = 1'b0;

        // Default parameters: 1289-cycle pass
        sel = 2'd2;
        build_model(64, 16, 10, 2);
        repeat ($urandom_range(1, 6)) @(negedge clk);
        go_c = 1'b1;
        full_pass();
        go_c = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
